// File: rtl/vdp_sprite_pkg.sv
// vdp_sprite_pkg: shared widths and the x-flip nibble reversal for the sprite VRAM fetch path
package vdp_sprite_pkg;
  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 32;
  localparam int PIXEL_BITS = 4;
  localparam int NIBBLES = VRAM_DATA_W / PIXEL_BITS;
  function automatic logic [VRAM_DATA_W-1:0] nibble_reverse32(input logic [VRAM_DATA_W-1:0] w);
    logic [VRAM_DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NIBBLES; k++) r[PIXEL_BITS*k +: PIXEL_BITS] = w[PIXEL_BITS*(NIBBLES-1-k) +: PIXEL_BITS];
    return r;
  endfunction
endpackage

// File: rtl/vdp_sprite_vram_fetch_pipe.sv
// vdp_sprite_fetch_pipe: {valid,flip} delay line tracking reads in flight, flushable on line restart
module vdp_sprite_fetch_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush_i,
  input  logic valid_i,
  input  logic flip_i,
  output logic valid_o,
  output logic flip_o
);
  logic [DEPTH-1:0] valid_q, valid_d, flip_q, flip_d;
  // shift one stage per cycle; a flush drops every in-flight valid bit
  always_comb begin
    valid_d = flush_i ? '0 : (valid_q << 1) | DEPTH'(valid_i);
    flip_d = (flip_q << 1) | DEPTH'(flip_i);
  end
  // state registers, cleared asynchronously so a reset abandons all reads in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      flip_q <= '0;
    end else begin
      valid_q <= valid_d;
      flip_q <= flip_d;
    end
  end
  assign valid_o = valid_q[DEPTH-1];
  assign flip_o = flip_q[DEPTH-1];
endmodule

// File: rtl/vdp_sprite_vram_fetch.sv
// vdp_sprite_vram_fetch: sprite VRAM read responder (slot scheduling, latency wait, x-flip); VDP_SPRITE_FETCH_STATS_EN adds missed_slots
module vdp_sprite_vram_fetch
  import vdp_sprite_pkg::*;
#(
  parameter int SLOT_PERIOD = 4,
  parameter int SLOT_PHASE = 0,
  parameter int VRAM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_new_line,
  input  logic                   fetch_enable,
  input  logic [VRAM_ADDR_W-1:0] sprite_read_address,
  input  logic                   sprite_read_x_flip,
  output logic [VRAM_DATA_W-1:0] sprite_read_data,
  output logic                   sprite_data_valid,
  output logic                   vram_req,
  output logic [VRAM_ADDR_W-1:0] vram_address,
  input  logic                   vram_grant,
`ifdef VDP_SPRITE_FETCH_STATS_EN
  output logic [7:0]             missed_slots,
`endif
  input  logic [VRAM_DATA_W-1:0] vram_read_data
);
  localparam int CW = SLOT_PERIOD > 1 ? $clog2(SLOT_PERIOD) : 1;
  logic [CW-1:0] slot_q, slot_d;
  logic [VRAM_DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, issue, ret_valid, ret_flip, capture;
  assign vram_req = slot_q == CW'(SLOT_PHASE) && fetch_enable && !start_new_line;
  assign vram_address = sprite_read_address;
  assign issue = vram_req && vram_grant;
  assign capture = ret_valid && !start_new_line;
  vdp_sprite_fetch_pipe #(.DEPTH(VRAM_LATENCY)) u_pipe (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(start_new_line),
    .valid_i(issue),
    .flip_i(sprite_read_x_flip),
    .valid_o(ret_valid),
    .flip_o(ret_flip)
  );
  // slot counter wraps every SLOT_PERIOD and realigns to the line start; returned word captured and flipped
  always_comb begin
    slot_d = (start_new_line || slot_q == CW'(SLOT_PERIOD - 1)) ? '0 : slot_q + 1'b1;
    data_d = capture ? (ret_flip ? nibble_reverse32(vram_read_data) : vram_read_data) : data_q;
    valid_d = capture;
  end
  // slot, output word and valid pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign sprite_read_data = data_q;
  assign sprite_data_valid = valid_q;
`ifdef VDP_SPRITE_FETCH_STATS_EN
  logic [7:0] missed_q, missed_d;
  // saturating count of offered-but-refused slots within the current line
  always_comb missed_d = start_new_line ? '0 : (vram_req && !vram_grant && missed_q != 8'hFF) ? missed_q + 1'b1 : missed_q;
  // missed-slot counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) missed_q <= '0;
    else missed_q <= missed_d;
  end
  assign missed_slots = missed_q;
`endif
endmodule
